seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx_pkg.sv | 23 ++
 rtl/seq_pattern_tx_if.sv | 24 ++
 rtl/seq_piso_shifter.sv | 49 ++++
 rtl/seq_pattern_tx.sv | 122 ++++++++++++
 tb/tb_seq_pattern_tx.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/seq_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
// SEQ_PREAMBLE_EN adds the PRE state to the FSM encoding.
package seq_pkg;

    localparam logic [3:0] PREAMBLE     = 4'b1010;
    localparam int         PREAMBLE_LEN = 4;

`ifdef SEQ_PREAMBLE_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2
    } state_t;
`endif

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Word-in / bit-out bundle of the serial pattern transmitter.
// master drives payload words, slave is the transmitter.
interface seq_pattern_tx_if #(
    parameter int DATA_W = 8
);

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              x;
    logic              x_valid;
    logic              done;

    modport master (
        output in_valid, in_data,
        input  in_ready, x, x_valid, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, x, x_valid, done
    );

endinterface

// File: rtl/seq_piso_shifter.sv
// Parallel-in serial-out payload register with remaining-bit counter.
// count_done_o flags the cycle presenting the final payload bit.
module seq_piso_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o,
    output logic              count_done_o
);

    localparam int CW = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] sh_q, sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    // Load a fresh word or shift one bit out; counter saturates at zero
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = data_i;
            cnt_d = CW'(DATA_W);
        end else if (shift_i) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Shift register and counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign msb_o        = sh_q[DATA_W-1];
    assign count_done_o = (cnt_q == CW'(1));

endmodule

// File: rtl/seq_pattern_tx.sv
// Serialises payload words MSB first, optionally behind a 1010 preamble,
// followed by a fixed idle gap. Preamble enabled by SEQ_PREAMBLE_EN.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input logic              clk,
    input logic              rst_n,
    seq_pattern_tx_if.slave  bus
);

    state_t     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic       go_q;
    logic       accept;
    logic       shift;
    logic       msb;
    logic       last;
`ifdef SEQ_PREAMBLE_EN
    logic [1:0] pre_q, pre_d;
`endif

    assign accept = bus.in_valid && bus.in_ready;
    assign shift  = (state_q == DATA);

    seq_piso_shifter #(
        .DATA_W (DATA_W)
    ) u_shifter (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (accept),
        .shift_i      (shift),
        .data_i       (bus.in_data),
        .msb_o        (msb),
        .count_done_o (last)
    );

    // State, counters, and ready enable that rises one edge after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gap_q   <= '0;
            go_q    <= 1'b0;
`ifdef SEQ_PREAMBLE_EN
            pre_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            go_q    <= 1'b1;
`ifdef SEQ_PREAMBLE_EN
            pre_q   <= pre_d;
`endif
        end
    end

    // Next state and per-state cycle counters
    always_comb begin
        state_d = state_q;
        gap_d   = '0;
`ifdef SEQ_PREAMBLE_EN
        pre_d   = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef SEQ_PREAMBLE_EN
                    state_d = PRE;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef SEQ_PREAMBLE_EN
            PRE: begin
                pre_d = pre_q + 2'd1;
                if (pre_q == 2'(PREAMBLE_LEN - 1)) begin
                    state_d = DATA;
                end
            end
`endif
            DATA: begin
                if (last) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 4'd1;
                if (gap_q == 4'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs per state; done marks the final payload bit
    always_comb begin
        bus.in_ready = 1'b0;
        bus.x        = 1'b0;
        bus.x_valid  = 1'b0;
        bus.done     = 1'b0;
        unique case (state_q)
            IDLE: bus.in_ready = go_q;
`ifdef SEQ_PREAMBLE_EN
            PRE: begin
                bus.x       = PREAMBLE[~pre_q];
                bus.x_valid = 1'b1;
            end
`endif
            DATA: begin
                bus.x       = msb;
                bus.x_valid = 1'b1;
                bus.done    = last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx; expectations follow SEQ_PREAMBLE_EN.
// DATA_W=8, GAP_CYCLES=3.
module tb_seq_pattern_tx;

    localparam int DW  = 8;
    localparam int GAP = 3;
`ifdef SEQ_PREAMBLE_EN
    localparam int PL = 4;
`else
    localparam int PL = 0;
`endif
    localparam int FL = DW + PL;
    localparam int BL = 2 * FL + GAP + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.DATA_W(DW)) bus ();

    seq_pattern_tx #(
        .DATA_W     (DW),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] bits;
        logic       hold;
        string      nm;
    } vec_t;

    vec_t          tab[6];
    logic [FL-1:0] got;
    logic [BL-1:0] vv, xx;
    logic          ok;
    int            n;
    int            hits;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [FL-1:0] framed(input logic [7:0] b);
`ifdef SEQ_PREAMBLE_EN
        return {4'b1010, b};
`else
        return b;
`endif
    endfunction

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && k < 64) begin
            @(negedge clk);
            k++;
        end
        chk({nm, ".rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic hold,
                        input string nm, output logic [FL-1:0] s);
        logic [FL-1:0] v, dn;
        logic          g;
        wait_ready(nm);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = hold;
        bus.in_data  = ~d;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            s[FL-1-i]  = bus.x;
            v[FL-1-i]  = bus.x_valid;
            dn[FL-1-i] = bus.done;
            if (i == FL - 1) bus.in_valid = 1'b0;
        end
        chk({nm, ".valid"}, 32'(v), 32'({FL{1'b1}}));
        chk({nm, ".done"}, 32'(dn), 32'd1);
        g = 1'b1;
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk);
            if (bus.x_valid | bus.in_ready | bus.x | bus.done) g = 1'b0;
        end
        chk({nm, ".gap"}, 32'(g), 32'd1);
        @(negedge clk);
        chk({nm, ".ret"}, 32'(bus.in_ready), 32'd1);
        if (hold) begin
            g = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (bus.x_valid | bus.done) g = 1'b0;
            end
            chk({nm, ".noq"}, 32'(g), 32'd1);
        end
    endtask

    initial begin
        tab[0] = '{8'hA5, 8'b1010_0101, 1'b0, "a5"};
        tab[1] = '{8'h0F, 8'b0000_1111, 1'b1, "0f_chg"};
        tab[2] = '{8'h80, 8'b1000_0000, 1'b0, "80"};
        tab[3] = '{8'h01, 8'b0000_0001, 1'b0, "01"};
        tab[4] = '{8'h00, 8'b0000_0000, 1'b0, "00"};
        tab[5] = '{8'h3C, 8'b0011_1100, 1'b0, "3c"};

        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        #12;
        chk("rst.out", 32'({bus.in_ready, bus.x, bus.x_valid, bus.done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.rdy_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst.rdy_up", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            send(tab[i].d, tab[i].hold, tab[i].nm, got);
            chk({tab[i].nm, ".x"}, 32'(got), 32'(framed(tab[i].bits)));
`ifdef SEQ_PREAMBLE_EN
            if (tab[i].d == 8'h00) begin
                hits = 0;
                for (int k = 0; k <= FL - 4; k++) begin
                    if (got[k +: 4] == 4'b1010) hits++;
                end
                chk("det.hits", 32'(hits), 32'd1);
            end
`endif
        end

        wait_ready("b2b");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        for (int i = 0; i < BL; i++) begin
            @(negedge clk);
            vv[BL-1-i] = bus.x_valid;
            xx[BL-1-i] = bus.x;
        end
        bus.in_valid = 1'b0;
        chk("b2b.valid", 32'(vv),
            32'({{FL{1'b1}}, {(GAP + 1){1'b0}}, {FL{1'b1}}}));
        chk("b2b.x", 32'(xx),
            32'({framed(8'hFF), {(GAP + 1){1'b0}}, framed(8'hFF)}));

        wait_ready("mid");
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (PL + 5) @(negedge clk);
        chk("mid.bit3", 32'({bus.x_valid, bus.x}), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.async", 32'({bus.in_ready, bus.x, bus.x_valid, bus.done}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid.rdy_low", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("mid.rdy_up", 32'(bus.in_ready), 32'd1);
        ok = 1'b1;
        n  = 0;
        for (int i = 0; i < FL + GAP; i++) begin
            @(negedge clk);
            if (bus.x_valid | bus.done) ok = 1'b0;
            if (bus.in_ready) n++;
        end
        chk("mid.quiet", 32'(ok), 32'd1);
        chk("mid.idle", 32'(n), 32'(FL + GAP));

        send(8'hA5, 1'b0, "post", got);
        chk("post.x", 32'(got), 32'(framed(8'b1010_0101)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
